// File: rtl/mant_div_iter.sv
// rtl/mant_div_iter.sv - iterative non-restoring radix-2 mantissa divider
// Produces a raw WIDTH_Q-bit quotient (1 integer bit) plus final remainder sign flags.
module mant_div_iter #(
  parameter int WIDTH_M = 24,
  parameter int WIDTH_Q = 28
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH_M-1:0] n,
  input  logic [WIDTH_M-1:0] d,
  output logic               busy,
  output logic               done,
  output logic [WIDTH_Q-1:0] q,
  output logic               rem_is_positive,
  output logic               rem_is_negative,
  output logic               div_by_zero
);

  localparam int WR = WIDTH_M + 2;
  localparam int WC = $clog2(WIDTH_Q);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH_M-1:0] n_q, n_d, d_q, d_d;
  logic [WR-1:0]      rem_q, rem_d;
  logic [WIDTH_Q-1:0] qa_q, qa_d, qm_q, qm_d;
  logic [WC-1:0]      cnt_q, cnt_d;
  logic [WIDTH_Q-1:0] q_q, q_d;
  logic               pos_q, pos_d, neg_q, neg_d, dz_q, dz_d;

  logic [WR-1:0]      rem_shift, rem_step, d_ext;
  logic [WIDTH_Q-1:0] qa_step, qm_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      d_q     <= '0;
      rem_q   <= '0;
      qa_q    <= '0;
      qm_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      rem_q   <= rem_d;
      qa_q    <= qa_d;
      qm_q    <= qm_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = ITER;
      ITER:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The first digit carries integer weight, so the remainder is not doubled on
  // that step. A zero remainder means the quotient is exact: it stays zero and
  // the converter appends 0 digits. qa/qm are the on-the-fly pair Q and Q-1ulp.
  always_comb begin
    rem_shift = (cnt_q == WC'(WIDTH_Q - 1)) ? rem_q : {rem_q[WR-2:0], 1'b0};
    d_ext     = {2'b00, d_q};
    if (rem_q == '0) begin
      rem_step = '0;
      qa_step  = {qa_q[WIDTH_Q-2:0], 1'b0};
      qm_step  = {qm_q[WIDTH_Q-2:0], 1'b1};
    end else if (!rem_q[WR-1]) begin
      rem_step = rem_shift - d_ext;
      qa_step  = {qa_q[WIDTH_Q-2:0], 1'b1};
      qm_step  = {qa_q[WIDTH_Q-2:0], 1'b0};
    end else begin
      rem_step = rem_shift + d_ext;
      qa_step  = {qm_q[WIDTH_Q-2:0], 1'b1};
      qm_step  = {qm_q[WIDTH_Q-2:0], 1'b0};
    end
  end

  always_comb begin
    n_d   = n_q;
    d_d   = d_q;
    rem_d = rem_q;
    qa_d  = qa_q;
    qm_d  = qm_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    pos_d = pos_q;
    neg_d = neg_q;
    dz_d  = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          n_d = n;
          d_d = d;
        end
      end
      LOAD: begin
        rem_d = {2'b00, n_q};
        qa_d  = '0;
        qm_d  = '1;
        cnt_d = WC'(WIDTH_Q - 1);
      end
      ITER: begin
        rem_d = rem_step;
        qa_d  = qa_step;
        qm_d  = qm_step;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WC'(1);
        end else if (d_q == '0) begin
          q_d   = '1;
          pos_d = 1'b0;
          neg_d = 1'b0;
          dz_d  = 1'b1;
        end else begin
          q_d   = qa_step;
          pos_d = (rem_step != '0) && !rem_step[WR-1];
          neg_d = rem_step[WR-1];
          dz_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  assign q               = q_q;
  assign rem_is_positive = pos_q;
  assign rem_is_negative = neg_q;
  assign div_by_zero     = dz_q;

endmodule
